// File: rtl/ram_burst_reader.sv
// Burst read engine in front of a single-port synchronous-read RAM.
// Streams sequential reads through a 2-entry buffer on a valid/ready output; idle host writes pass through.
module ram_burst_reader #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic [AW-1:0] ram_add,
    output logic [DW-1:0] ram_din,
    output logic          ram_wr_en,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [AW:0] MaxLen = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] One    = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   remaining_q, total_q, beat_q;
    logic          inflight_q, done_q;
    logic [1:0]    count_q;
    logic          head_q, tail_q;
    logic [DW-1:0] buf_data_q [2];
    logic          buf_last_q [2];

    logic [AW:0] len_clamped;
    logic        start_ok, push, pop, last_pop, issue;
    logic [2:0]  occ;

    assign len_clamped = (len > MaxLen) ? MaxLen : len;
    assign start_ok    = (state_q == StIdle) && start;
    assign push        = inflight_q;
    assign pop         = (count_q != 2'd0) && m_ready;
    assign last_pop    = pop && buf_last_q[head_q];
    // Occupancy after this cycle's pop, counting the word still in flight from the RAM.
    assign occ         = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign m_valid = (count_q != 2'd0);
    assign m_data  = buf_data_q[head_q];
    assign m_last  = m_valid && buf_last_q[head_q];
    assign done    = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start && len_clamped != '0) state_d = StRead;
            StRead:  if (issue && remaining_q == One) state_d = StDrain;
            StDrain: if (last_pop) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        issue     = 1'b0;
        ram_add   = '0;
        ram_din   = '0;
        ram_wr_en = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                StIdle: begin
                    ram_add   = wr_addr;
                    ram_din   = wr_data;
                    ram_wr_en = wr_req && !start;
                end
                StRead: begin
                    ram_add = rd_ptr_q;
                    issue   = (remaining_q != '0) && (occ < 3'd2);
                end
                StDrain: ram_add = rd_ptr_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q      <= '0;
            remaining_q   <= '0;
            total_q       <= '0;
            beat_q        <= '0;
            inflight_q    <= 1'b0;
            done_q        <= 1'b0;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q[0] <= 1'b0;
            buf_last_q[1] <= 1'b0;
        end else begin
            inflight_q <= issue;
            done_q     <= (start_ok && len_clamped == '0) || (state_q == StDrain && last_pop);

            if (push) begin
                buf_data_q[tail_q] <= ram_dout;
                buf_last_q[tail_q] <= (beat_q == total_q - One);
                tail_q             <= ~tail_q;
                beat_q             <= beat_q + One;
            end
            if (pop) begin
                head_q <= ~head_q;
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase

            if (start_ok) begin
                rd_ptr_q    <= start_addr;
                remaining_q <= len_clamped;
                total_q     <= len_clamped;
                beat_q      <= '0;
            end else if (issue) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                remaining_q <= remaining_q - One;
            end
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: RAM model, reference queue of expected beats, per-cycle compare,
// directed scenarios with literal expectations, then randomized bursts with backpressure.
module tb_ram_burst_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] start_addr = '0;
    logic [4:0] len = '0;
    logic       busy, done;
    logic       wr_req = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       m_valid, m_last;
    logic [7:0] m_data;
    logic       m_ready = 1'b1;
    logic [3:0] ram_add;
    logic [7:0] ram_din;
    logic       ram_wr_en;
    logic [7:0] ram_dout = '0;

    ram_burst_reader #(.AW(4), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
        .busy(busy), .done(done), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .ram_add(ram_add), .ram_din(ram_din), .ram_wr_en(ram_wr_en), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // 16x8 single-port RAM, synchronous read
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_add] <= ram_din;
        ram_dout <= mem[ram_add];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed { logic [7:0] d; logic l; } beat_t;
    beat_t      exp_q[$];
    logic [7:0] model_mem [16];
    logic [7:0] got_data[$];
    logic       got_last[$];
    bit         model_busy = 0, done_due = 0, prev_stall = 0;
    logic [7:0] prev_data;
    logic       prev_last;
    int         cyc = 0, accept_cyc = 0, first_valid_cyc = -1, last_xfer_cyc = 0, done_cnt = 0;

    always @(posedge clk) cyc++;

    // Reference model and per-cycle compare, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_m_last", m_last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_ram_wr_en", ram_wr_en, 0);
            chk("rst_ram_add", ram_add, 0);
            chk("rst_ram_din", ram_din, 0);
            exp_q.delete();
            model_busy = 0;
            done_due   = 0;
            prev_stall = 0;
        end else begin
            bit exp_wr, xfer_last, was_busy;
            int n;
            chk("done", done, done_due);
            chk("busy", busy, model_busy);
            if (done) done_cnt++;
            exp_wr = !model_busy && wr_req && !start;
            chk("ram_wr_en", ram_wr_en, exp_wr);
            if (exp_wr) begin
                chk("ram_add_wr", ram_add, wr_addr);
                chk("ram_din_wr", ram_din, wr_data);
                model_mem[wr_addr] = wr_data;
            end
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            xfer_last = 0;
            if (m_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", m_valid, 0);
                end else begin
                    chk("m_data", m_data, exp_q[0].d);
                    chk("m_last", m_last, exp_q[0].l);
                    if (m_ready) begin
                        got_data.push_back(m_data);
                        got_last.push_back(m_last);
                        last_xfer_cyc = cyc;
                        xfer_last = exp_q[0].l;
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            was_busy   = model_busy;
            done_due   = xfer_last;
            if (xfer_last) model_busy = 0;
            if (!was_busy && start) begin
                n = (len > 5'd16) ? 16 : int'(len);
                accept_cyc = cyc;
                if (n == 0) done_due = 1;
                else model_busy = 1;
                for (int i = 0; i < n; i++)
                    exp_q.push_back('{d: model_mem[(int'(start_addr) + i) % 16], l: (i == n - 1)});
            end
        end
    end

    // m_ready source: 0 = always high, 1 = fixed 1,0,0,1,0,1 pattern, 2 = random
    int         ready_mode = 0;
    int         pidx = 0;
    logic [5:0] pat = 6'b101001;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: begin m_ready = pat[pidx % 6]; pidx++; end
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] a, input logic [7:0] d);
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_req = 1'b0;
    endtask

    task automatic start_burst(input logic [3:0] a, input logic [4:0] l);
        got_data.delete(); got_last.delete();
        done_cnt = 0; first_valid_cyc = -1;
        start = 1'b1; start_addr = a; len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        int k = 0;
        while ((model_busy || exp_q.size() != 0) && k < 400) begin
            if (rnd && model_busy) begin
                start = 1'($urandom_range(0, 1)); start_addr = 4'($urandom); len = 5'($urandom);
                wr_req = 1'($urandom_range(0, 1)); wr_addr = 4'($urandom); wr_data = 8'($urandom);
            end else begin
                start = 1'b0; wr_req = 1'b0;
            end
            tick();
            k++;
        end
        start = 1'b0; wr_req = 1'b0;
        if (k >= 400) chk("burst_timeout", 1, 0);
        tick();
        tick();
    endtask

    initial begin
        logic [7:0] lit4 [4];
        logic [7:0] rdat [8];
        lit4[0] = 8'h11; lit4[1] = 8'h22; lit4[2] = 8'h33; lit4[3] = 8'h44;
        for (int i = 0; i < 16; i++) begin mem[i] = '0; model_mem[i] = '0; end
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Basic burst, m_ready high
        for (int i = 0; i < 4; i++) write(4'(i), lit4[i]);
        start_burst(4'd0, 5'd4);
        wait_idle(0);
        chk("b1_count", got_data.size(), 4);
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            chk("b1_data", got_data[i], lit4[i]);
            chk("b1_last", got_last[i], (i == 3));
        end
        chk("b1_latency", first_valid_cyc - accept_cyc, 3);
        chk("b1_back_to_back", last_xfer_cyc - first_valid_cyc, 3);
        chk("b1_done_once", done_cnt, 1);

        // Same burst under a fixed backpressure pattern
        ready_mode = 1; pidx = 0;
        start_burst(4'd0, 5'd4);
        wait_idle(0);
        chk("b2_count", got_data.size(), 4);
        for (int i = 0; i < 4 && i < got_data.size(); i++) chk("b2_data", got_data[i], lit4[i]);
        chk("b2_done_once", done_cnt, 1);

        // Address wrap 15 -> 0
        ready_mode = 0;
        write(4'd15, 8'hF0);
        write(4'd0, 8'h0F);
        start_burst(4'd15, 5'd2);
        wait_idle(0);
        chk("wrap_count", got_data.size(), 2);
        if (got_data.size() == 2) begin
            chk("wrap_d0", got_data[0], 8'hF0);
            chk("wrap_d1", got_data[1], 8'h0F);
            chk("wrap_l0", got_last[0], 0);
            chk("wrap_l1", got_last[1], 1);
        end

        // Oversized length clamps to 16 words
        for (int i = 0; i < 16; i++) write(4'(i), 8'($urandom));
        start_burst(4'd6, 5'd20);
        wait_idle(0);
        chk("clamp_count", got_data.size(), 16);
        chk("clamp_last_latency", last_xfer_cyc - accept_cyc, 18);
        chk("clamp_done_once", done_cnt, 1);

        // Empty burst
        start_burst(4'd3, 5'd0);
        wait_idle(0);
        chk("len0_words", got_data.size(), 0);
        chk("len0_done_once", done_cnt, 1);

        // start and wr_req together: the write is dropped
        write(4'd5, 8'h55);
        wr_req = 1'b1; wr_addr = 4'd5; wr_data = 8'hA5;
        start_burst(4'd5, 5'd2);
        wr_req = 1'b0;
        wait_idle(0);
        chk("drop_wr_mem", mem[5], 8'h55);
        chk("drop_wr_d0", got_data.size() > 0 ? got_data[0] : 8'hXX, 8'h55);

        // Reset in the middle of an 8-word burst
        for (int i = 0; i < 8; i++) begin rdat[i] = 8'($urandom); write(4'(i), rdat[i]); end
        start_burst(4'd0, 5'd8);
        for (int k = 0; k < 50 && got_data.size() < 2; k++) tick();
        chk("pre_reset_words", got_data.size(), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_m_valid", m_valid, 0);
        chk("async_m_data", m_data, 0);
        chk("async_m_last", m_last, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_ram_wr_en", ram_wr_en, 0);
        chk("async_ram_add", ram_add, 0);
        chk("async_ram_din", ram_din, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) chk("mem_kept", mem[i], rdat[i]);
        start_burst(4'd4, 5'd3);
        wait_idle(0);
        chk("post_reset_count", got_data.size(), 3);
        for (int i = 0; i < 3 && i < got_data.size(); i++) chk("post_reset_data", got_data[i], rdat[4 + i]);

        // Randomized bursts with random backpressure and ignored start/wr_req while busy
        ready_mode = 2;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 1) write(4'($urandom), 8'($urandom));
            start_burst(4'($urandom), 5'($urandom_range(0, 31)));
            wait_idle(1);
            chk("rnd_done_once", done_cnt, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
